// File: rtl/constant_bank.sv
// Registered tie-off constant bank: SAFE_VAL through reset and settle, then INIT_VAL, masked writes until lock.
// Optional CONST_BANK_SHADOW_EN adds a shadow copy of val and a sticky mismatch flag on err.
module constant_bank #(
    parameter int unsigned     NCH           = 8,
    parameter logic [NCH-1:0]  SAFE_VAL      = '0,
    parameter logic [NCH-1:0]  INIT_VAL      = '0,
    parameter int unsigned     SETTLE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [NCH-1:0]  wr_mask,
    input  logic [NCH-1:0]  wr_data,
    input  logic            lock,
    output logic [NCH-1:0]  val,
    output logic [NCH-1:0]  val_n,
    output logic            released,
    output logic            locked,
    output logic            err
);

    localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {SETTLE, ACTIVE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]  val_d;
    logic            released_d, ready_d, locked_d;
    logic            write_fire;

    assign write_fire = wr_valid & wr_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        val_d      = val;
        released_d = released;
        ready_d    = wr_ready;
        locked_d   = locked;
        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    val_d      = INIT_VAL;
                    released_d = 1'b1;
                    ready_d    = 1'b1;
                    state_d    = ACTIVE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACTIVE: begin
                // A write in the lock cycle still lands before the bank freezes.
                if (write_fire) begin
                    val_d = (val & ~wr_mask) | (wr_data & wr_mask);
                end
                if (lock) begin
                    locked_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = LOCKED;
                end
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            val      <= SAFE_VAL;
            val_n    <= ~SAFE_VAL;
            released <= 1'b0;
            wr_ready <= 1'b0;
            locked   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            val      <= val_d;
            val_n    <= ~val_d;
            released <= released_d;
            wr_ready <= ready_d;
            locked   <= locked_d;
        end
    end

`ifdef CONST_BANK_SHADOW_EN
    logic [NCH-1:0] shadow_q, shadow_d;

    // Shadow follows its own copy of the update rule so a corrupted val is not propagated into it.
    always_comb begin
        shadow_d = shadow_q;
        if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                shadow_d = INIT_VAL;
            end
        end else if (state_q == ACTIVE && write_fire) begin
            shadow_d = (shadow_q & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_q <= SAFE_VAL;
            err      <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if ((val != shadow_q) || (val_n != ~shadow_q)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
